// File: rtl/seq_divider_8by4.sv
// -----------------------------------------------------------------------------
// seq_divider_8by4
//
// Purpose:
//   Sequential restoring divider: 8-bit unsigned dividend / 4-bit unsigned
//   divisor -> 8-bit quotient + 4-bit remainder, one quotient bit per clock.
//   Companion of the 4x4 multiplier; used by the matrix unit to normalise and
//   scale 8-bit products.
//
// Ports:
//   clk          in   1  clock, all state updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset
//   in_valid     in   1  dividend/divisor valid
//   in_ready     out  1  block can accept an operation (state IDLE)
//   dividend     in   8  unsigned dividend
//   divisor      in   4  unsigned divisor
//   out_valid    out  1  result valid (state DONE)
//   out_ready    in   1  consumer accepts result
//   quotient     out  8  unsigned quotient (8'hFF on divide-by-zero)
//   remainder    out  4  unsigned remainder (dividend[3:0] on divide-by-zero)
//   div_by_zero  out  1  result came from divisor == 0
//
// Optional feature:
//   SEQ_DIVIDER_EARLY_EXIT_EN - when defined, the bit counter starts at the
//   index of the dividend's highest set bit, skipping leading zeros. Results
//   are identical; only latency changes (msb_index+1 CALC edges, 1 edge for a
//   zero dividend). When undefined every nonzero divisor takes 8 CALC edges.
// -----------------------------------------------------------------------------
module seq_divider_8by4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    // Operand latches: operands are captured once at acceptance and never
    // re-sampled, so the producer may change them freely during CALC.
    logic [7:0] r_dividend;
    logic [3:0] r_divisor;

    // Partial remainder. After each restoring step it is strictly below the
    // divisor, so four stored bits suffice; the shifted-in value used for the
    // compare is the full 5 bits and therefore cannot overflow.
    logic [3:0] r_partial;
    logic [2:0] r_count;
    logic [7:0] r_q;

    // Result registers, held through DONE and back into IDLE.
    logic [7:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_div_by_zero;

    // One restoring step
    logic [4:0] w_shift;
    logic [4:0] w_divisor_ext;
    logic       w_ge;
    logic [3:0] w_diff;
    logic [3:0] w_partial_next;
    logic [7:0] w_q_next;
    logic       w_last;
    logic [2:0] w_start_count;

    assign w_shift       = {r_partial, r_dividend[r_count]};
    assign w_divisor_ext = {1'b0, r_divisor};
    assign w_ge          = (w_shift >= w_divisor_ext);
    // Only used when w_shift >= divisor, in which case the true difference
    // is below the divisor and fits in 4 bits, so modular 4-bit math is exact.
    assign w_diff        = w_shift[3:0] - r_divisor;
    assign w_partial_next = w_ge ? w_diff : w_shift[3:0];
    assign w_last        = (r_count == 3'd0);

    always_comb begin
        w_q_next          = r_q;
        w_q_next[r_count] = w_ge;
    end

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    // Leading-zero skip: start at the highest set dividend bit. The ascending
    // loop leaves the highest index in place. A zero dividend starts at 0 and
    // still spends one CALC edge, producing quotient 0 and remainder 0.
    always_comb begin
        w_start_count = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (dividend[k]) begin
                w_start_count = 3'(k);
            end
        end
    end
`else
    assign w_start_count = 3'd7;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    // Divide-by-zero skips the iteration entirely.
                    w_state_next = (divisor == 4'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend    <= 8'd0;
            r_divisor     <= 4'd0;
            r_partial     <= 4'd0;
            r_count       <= 3'd0;
            r_q           <= 8'd0;
            r_quotient    <= 8'd0;
            r_remainder   <= 4'd0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (divisor != 4'd0) begin
                            r_dividend <= dividend;
                            r_divisor  <= divisor;
                            r_partial  <= 4'd0;
                            r_q        <= 8'd0;
                            r_count    <= w_start_count;
                        end else begin
                            r_quotient    <= 8'hFF;
                            r_remainder   <= dividend[3:0];
                            r_div_by_zero <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_partial <= w_partial_next;
                    r_q       <= w_q_next;
                    // Wraps to 7 after the last bit; harmless since the next
                    // acceptance reloads it.
                    r_count   <= r_count - 3'd1;
                    if (w_last) begin
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_partial_next;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    // DONE: results held until the consumer takes them.
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_8by4
//
// Directed self-checking bench for seq_divider_8by4. Expected latency follows
// SEQ_DIVIDER_EARLY_EXIT_EN when the bench is built with the same define.
// -----------------------------------------------------------------------------
module tb_seq_divider_8by4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;

    seq_divider_8by4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for exactly one edge, then scramble the operands
    // so that any late sampling inside the DUT corrupts the result.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Edges from acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Expected edges from acceptance to out_valid.
    function automatic int exp_lat(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return 0;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
        for (int k = 7; k >= 0; k--) begin
            if (a[k]) return k + 1;
        end
        return 1;
`else
        return 8;
`endif
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 4'd0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: q=%0d r=%0d dbz=%b required 0 0 0", quotient, remainder, div_by_zero);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_basic();
        int  n;
        bit  busy_ready;
        start_op(8'd200, 4'd7);
        n = 0;
        busy_ready = 1'b0;
        while (!out_valid && n < 30) begin
            if (in_ready !== 1'b0) busy_ready = 1'b1;
            tick();
            n++;
        end
        if (!out_valid) n = -1;
        $display("op 200/7 -> q=%0d r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, n);
        checks++;
        if (busy_ready) begin
            failures++;
            $display("FAIL basic_in_ready: in_ready seen 1 during CALC required 0");
        end
        checks++;
        if (n != exp_lat(8'd200, 4'd7)) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d", n, exp_lat(8'd200, 4'd7));
        end
        checks++;
        if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b required 28 4 0", quotient, remainder, div_by_zero);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd28 || remainder !== 4'd4) begin
            failures++;
            $display("FAIL basic_release: ov=%b ir=%b q=%0d r=%0d required 0 1 28 4", out_valid, in_ready, quotient, remainder);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_values();
        logic [7:0] ta [8] = '{8'd255, 8'd5, 8'd15, 8'd0, 8'd254, 8'd1, 8'd128, 8'd9};
        logic [3:0] tb [8] = '{4'd1, 4'd15, 4'd15, 4'd5, 4'd15, 4'd1, 4'd3, 4'd2};
        logic [7:0] tq [8] = '{8'd255, 8'd0, 8'd1, 8'd0, 8'd16, 8'd1, 8'd42, 8'd4};
        logic [3:0] tr [8] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd14, 4'd0, 4'd2, 4'd1};
        int n;
        for (int i = 0; i < 8; i++) begin
            start_op(ta[i], tb[i]);
            // out_ready high during CALC must be ignored.
            out_ready = (i % 2 == 1);
            wait_valid(n);
            $display("op %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", ta[i], tb[i], quotient, remainder, div_by_zero, n);
            checks++;
            if (n != exp_lat(ta[i], tb[i])) begin
                failures++;
                $display("FAIL values_latency[%0d]: got %0d required %0d", i, n, exp_lat(ta[i], tb[i]));
            end
            checks++;
            if (quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL values_result[%0d]: q=%0d r=%0d dbz=%b required %0d %0d 0", i, quotient, remainder, div_by_zero, tq[i], tr[i]);
            end
            release_out();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_div_zero();
        int n;
        start_op(8'd77, 4'd0);
        wait_valid(n);
        $display("op 77/0 -> q=%0d r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL dbz_latency: got %0d required 0", n);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 4'hD || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result: q=%h r=%h dbz=%b required ff d 1", quotient, remainder, div_by_zero);
        end
        release_out();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int n;
        start_op(8'd50, 4'd6);
        wait_valid(n);
        $display("op 50/6 -> q=%0d r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, n);
        checks++;
        if (n != exp_lat(8'd50, 4'd6)) begin
            failures++;
            $display("FAIL bp_latency: got %0d required %0d", n, exp_lat(8'd50, 4'd6));
        end
        // New operation offered while the result is stalled.
        out_ready = 1'b0;
        dividend  = 8'd99;
        divisor   = 4'd4;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd8 ||
                remainder !== 4'd2 || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b q=%0d r=%0d dbz=%b required 1 0 8 2 0",
                         c, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd8) begin
            failures++;
            $display("FAIL bp_release: ov=%b ir=%b q=%0d required 0 1 8", out_valid, in_ready, quotient);
        end
        tick();     // in_valid still high: accepted on this edge
        in_valid = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: in_ready=%b required 0", in_ready);
        end
        wait_valid(n);
        $display("op 99/4 -> q=%0d r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, n);
        checks++;
        if (n != exp_lat(8'd99, 4'd4) || quotient !== 8'd24 || remainder !== 4'd3) begin
            failures++;
            $display("FAIL bp_second: lat=%0d q=%0d r=%0d required %0d 24 3", n, quotient, remainder, exp_lat(8'd99, 4'd4));
        end
        release_out();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        int n;
        start_op(8'd200, 4'd7);
        for (int c = 0; c < 4; c++) tick();   // four CALC edges
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-CALC");
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd0 ||
            remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: ov=%b ir=%b q=%0d r=%0d dbz=%b required 0 1 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        tick();
        rst_n = 1'b1;
        start_op(8'd100, 4'd3);
        wait_valid(n);
        $display("op 100/3 -> q=%0d r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, n);
        checks++;
        if (n != exp_lat(8'd100, 4'd3) || quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next: lat=%0d q=%0d r=%0d dbz=%b required %0d 33 1 0",
                     n, quotient, remainder, div_by_zero, exp_lat(8'd100, 4'd3));
        end
        release_out();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        int         n;
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            if (b == 4'd0) begin
                eq = 8'hFF;
                er = a[3:0];
                ez = 1'b1;
            end else begin
                eq = a / {4'd0, b};
                er = 4'(a % {4'd0, b});
                ez = 1'b0;
            end
            start_op(a, b);
            wait_valid(n);
            $display("op %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", a, b, quotient, remainder, div_by_zero, n);
            checks++;
            if (n != exp_lat(a, b) || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                failures++;
                $display("FAIL random[%0d] %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required %0d %0d %0d %b",
                         i, a, b, n, quotient, remainder, div_by_zero, exp_lat(a, b), eq, er, ez);
            end
            release_out();
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_div_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
